// File: rtl/rng_pkg.sv
// rng_pkg: shared xorshift128 types, default seed, step function and arbiter states
package rng_pkg;
  localparam logic [31:0] X0 = 32'd123456789;
  localparam logic [31:0] Y0 = 32'd362436069;
  localparam logic [31:0] Z0 = 32'd521288629;
  localparam logic [31:0] W0 = 32'd88675123;
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] w;
  } rng_state_t;
  localparam rng_state_t SEED0 = '{x: X0, y: Y0, z: Z0, w: W0};
  typedef enum logic {S_WARMUP, S_SERVE} fsm_t;
  function automatic rng_state_t xorshift_next(rng_state_t s);
    logic [31:0] t;
    t = s.x ^ (s.x << 11);
    return '{x: s.y, y: s.z, z: s.w, w: s.w ^ (s.w >> 19) ^ t ^ (t >> 8)};
  endfunction
endpackage

// File: rtl/xorshift128_core.sv
// xorshift128_core: xorshift128 state register with seed load, single-step and all-zero guard
module xorshift128_core
  import rng_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         step,
  input  logic         load,
  input  logic [127:0] seed,
  output rng_state_t   state,
  output logic [31:0]  next_w
);
  rng_state_t nxt;
  assign nxt = xorshift_next(state);
  assign next_w = nxt.w;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= SEED0;
    else if (load) state <= seed == '0 ? SEED0 : rng_state_t'(seed);
    else if (step) state <= nxt == '0 ? SEED0 : nxt;
endmodule

// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin sharing of one xorshift128 generator with warm-up and reseed
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WARMUP = 16,
  parameter int ID_W   = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  input  logic             seed_valid,
  input  logic [127:0]     seed_data,
  output logic             busy,
  output logic             rsp_valid,
  output logic [ID_W-1:0]  rsp_id,
  output logic [31:0]      rsp_data,
  output logic [31:0]      draw_count
);
  localparam fsm_t ST0 = WARMUP == 0 ? S_SERVE : S_WARMUP;
  localparam logic [7:0] WU = 8'(WARMUP);
  fsm_t st, st_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [ID_W-1:0] ptr, win;
  logic [ID_W:0] idx;
  logic hit, grant, step;
  logic [31:0] next_w;
  rng_state_t gen_unused;
  xorshift128_core u_core (
    .clk(clk),
    .rstn(rstn),
    .step(step),
    .load(seed_valid),
    .seed(seed_data),
    .state(gen_unused),
    .next_w(next_w)
  );
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (ID_W+1)'(ptr) + (ID_W+1)'(i);
      idx = idx >= (ID_W+1)'(N_REQ) ? idx - (ID_W+1)'(N_REQ) : idx;
      if (req[idx[ID_W-1:0]]) begin
        hit = 1'b1;
        win = idx[ID_W-1:0];
      end
    end
  end
  assign busy  = st == S_WARMUP;
  assign grant = st == S_SERVE && hit && !seed_valid;
  assign gnt   = grant ? N_REQ'(1) << win : '0;
  assign step  = !seed_valid && (busy || grant);
  always_comb begin
    st_nxt  = seed_valid ? ST0 : busy && cnt == 8'd1 ? S_SERVE : st;
    cnt_nxt = seed_valid ? WU : busy ? cnt - 8'd1 : cnt;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st         <= ST0;
      cnt        <= WU;
      ptr        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      draw_count <= '0;
    end else begin
      st        <= st_nxt;
      cnt       <= cnt_nxt;
      rsp_valid <= grant;
      if (grant) begin
        ptr        <= win == ID_W'(N_REQ - 1) ? '0 : win + 1'b1;
        rsp_id     <= win;
        rsp_data   <= next_w;
        draw_count <= draw_count + 32'd1;
      end
    end
endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: two arbiters (WARMUP 0 and 16) on shared stimulus, checked against a behavioural model
module tb_rng_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [3:0] req = '0;
  logic seed_valid = 1'b0;
  logic [127:0] seed_data = '0;
  logic [3:0] gnt[2];
  logic busy[2], rv[2];
  logic [1:0] rid[2];
  logic [31:0] rd[2], dc[2];
  int total = 0, bad = 0;
  logic [31:0] g[2][4];
  int m_wu[2], m_ptr[2], m_rid[2];
  logic m_rv[2];
  logic [31:0] m_rd[2], m_cnt[2];
  always #5 clk = ~clk;
  rng_arbiter #(.N_REQ(4), .WARMUP(0)) dut0 (
    .clk(clk), .rstn(rstn), .req(req), .gnt(gnt[0]), .seed_valid(seed_valid),
    .seed_data(seed_data), .busy(busy[0]), .rsp_valid(rv[0]), .rsp_id(rid[0]),
    .rsp_data(rd[0]), .draw_count(dc[0])
  );
  rng_arbiter #(.N_REQ(4), .WARMUP(16)) dut1 (
    .clk(clk), .rstn(rstn), .req(req), .gnt(gnt[1]), .seed_valid(seed_valid),
    .seed_data(seed_data), .busy(busy[1]), .rsp_valid(rv[1]), .rsp_id(rid[1]),
    .rsp_data(rd[1]), .draw_count(dc[1])
  );
  task automatic chk(string n, int d, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d", n, d, a, e);
    end
  endtask
  function automatic int wu_of(int d);
    return d == 0 ? 0 : 16;
  endfunction
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      g[d] = '{32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123};
      m_wu[d] = wu_of(d);
      m_ptr[d] = 0;
      m_rid[d] = 0;
      m_rv[d] = 1'b0;
      m_rd[d] = '0;
      m_cnt[d] = '0;
    end
  endtask
  function automatic int win(int d);
    if (m_wu[d] > 0 || seed_valid || req == 4'b0) return -1;
    for (int k = 0; k < 4; k++)
      if (req[(m_ptr[d] + k) % 4]) return (m_ptr[d] + k) % 4;
    return -1;
  endfunction
  task automatic gen_step(int d);
    logic [31:0] t, nw;
    t = g[d][0] ^ (g[d][0] << 11);
    nw = g[d][3] ^ (g[d][3] >> 19) ^ t ^ (t >> 8);
    g[d][0] = g[d][1];
    g[d][1] = g[d][2];
    g[d][2] = g[d][3];
    g[d][3] = nw;
  endtask
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int w;
      w = win(d);
      m_rv[d] = 1'b0;
      if (seed_valid) begin
        if (seed_data == '0) g[d] = '{32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123};
        else g[d] = '{seed_data[127:96], seed_data[95:64], seed_data[63:32], seed_data[31:0]};
        m_wu[d] = wu_of(d);
      end else if (m_wu[d] > 0) begin
        gen_step(d);
        m_wu[d]--;
      end else if (w >= 0) begin
        gen_step(d);
        m_rv[d] = 1'b1;
        m_rd[d] = g[d][3];
        m_rid[d] = w;
        m_cnt[d]++;
        m_ptr[d] = (w + 1) % 4;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (rstn) model_edge();
    #2;
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask
  task automatic busy_run(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (gnt[1] != 4'b0) break;
      if (busy[1]) n++;
      tick();
    end
  endtask
  always @(negedge clk)
    if (rstn)
      for (int d = 0; d < 2; d++) begin
        int w;
        w = win(d);
        chk("gnt", d, 32'(gnt[d]), w < 0 ? 32'd0 : 32'd1 << w);
        chk("busy", d, 32'(busy[d]), 32'(m_wu[d] > 0));
        chk("rsp_valid", d, 32'(rv[d]), 32'(m_rv[d]));
        chk("rsp_id", d, 32'(rid[d]), m_rid[d]);
        chk("rsp_data", d, rd[d], m_rd[d]);
        chk("draw_count", d, dc[d], m_cnt[d]);
      end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [31:0] exp1[3];
    int n;
    exp1 = '{32'd3701687786, 32'd458299110, 32'd2500872618};
    model_reset();
    do_reset();
    #1;
    chk("rst rsp_valid", 0, 32'(rv[0]), 0);
    chk("rst rsp_data", 0, rd[0], 0);
    chk("rst draw_count", 0, dc[0], 0);
    chk("rst busy", 0, 32'(busy[0]), 0);
    chk("rst busy", 1, 32'(busy[1]), 1);
    chk("rst rsp_id", 1, 32'(rid[1]), 0);
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("seq data", 0, rd[0], exp1[k]);
      chk("seq id", 0, 32'(rid[0]), 0);
      chk("seq valid", 0, 32'(rv[0]), 1);
    end
    chk("seq count", 0, dc[0], 3);
    req = 4'b0;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr gnt", 0, 32'(gnt[0]), 32'd1 << (k % 4));
      tick();
      chk("rr valid", 0, 32'(rv[0]), 1);
      if (k == 0) chk("rr first data", 0, rd[0], 32'd3701687786);
    end
    req = 4'b0;
    do_reset();
    req = 4'b0001;
    busy_run(n);
    chk("warmup cycles", 1, n, 16);
    chk("warmup first gnt", 1, 32'(gnt[1]), 1);
    tick();
    #1;
    chk("warmup first valid", 1, 32'(rv[1]), 1);
    req = 4'b0010;
    seed_valid = 1'b1;
    seed_data = '0;
    #1;
    chk("seed gnt", 0, 32'(gnt[0]), 0);
    chk("seed gnt", 1, 32'(gnt[1]), 0);
    tick();
    seed_valid = 1'b0;
    #1;
    chk("after seed gnt", 0, 32'(gnt[0]), 32'b0010);
    tick();
    #1;
    chk("zero seed data", 0, rd[0], 32'd3701687786);
    chk("zero seed id", 0, 32'(rid[0]), 1);
    req = 4'b0;
    seed_valid = 1'b1;
    seed_data = {32'd1, 32'd2, 32'd3, 32'd4};
    tick();
    seed_valid = 1'b0;
    req = 4'b0100;
    tick();
    #1;
    chk("seed 1234 data", 0, rd[0], 32'd2061);
    chk("seed 1234 id", 0, 32'(rid[0]), 2);
    req = 4'b0;
    do_reset();
    req = 4'b0001;
    repeat (11) tick();
    #1;
    chk("pre-reset count", 0, dc[0], 11);
    rstn = 1'b0;
    model_reset();
    #1;
    chk("async rsp_valid", 0, 32'(rv[0]), 0);
    chk("async draw_count", 0, dc[0], 0);
    chk("async rsp_data", 0, rd[0], 0);
    chk("async busy", 1, 32'(busy[1]), 1);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    busy_run(n);
    chk("rewarm cycles", 1, n, 16);
    req = 4'b0;
    tick();
    force dut0.draw_count = 32'hFFFFFFFF;
    force dut1.draw_count = 32'hFFFFFFFF;
    #1;
    release dut0.draw_count;
    release dut1.draw_count;
    m_cnt[0] = 32'hFFFFFFFF;
    m_cnt[1] = 32'hFFFFFFFF;
    req = 4'b0001;
    tick();
    #1;
    chk("wrap count", 0, dc[0], 0);
    chk("wrap count", 1, dc[1], 0);
    chk("wrap valid", 0, 32'(rv[0]), 1);
    chk("wrap valid", 1, 32'(rv[1]), 1);
    req = 4'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
